inst_fetch: RTL and testbench

- Fetch stage directly downstream of the instruction cache: owns the PC, drives the cache address and captures the 32-bit word the cache returns one clock later.
- Buffers fetched words in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Supports redirect from execute (branch/jump): flushes in-flight and queued words.
- PC is a word address: cache word offset = PC[4:0], index = PC[6:5], tag = PC[31:7], so sequential fetch increments by 1.

---
 rtl/inst_fetch.sv | 112 +++++++++++
 tb/tb_inst_fetch.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, drives the instruction cache address, captures the
// returned word a cycle later and presents it to decode through a 2-entry queue.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] cache_addr,
  input  logic [31:0] cache_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam logic [1:0] QFULL = 2'(QDEPTH);

  logic [31:0] pc_q, pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] last_inst_q, last_inst_d;
  logic [31:0] last_pc_q, last_pc_d;
  logic [31:0] qinst_q [2];
  logic [31:0] qpc_q   [2];

  logic       pop;
  logic       push;
  logic       issue;
  logic [1:0] count_base;

  assign cache_addr = pc_q;
  assign inst_valid = (count_q != 2'd0);
  assign inst       = inst_valid ? qinst_q[rd_ptr_q] : last_inst_q;
  assign inst_pc    = inst_valid ? qpc_q[rd_ptr_q]   : last_pc_q;

  assign pop        = inst_valid & inst_ready;
  assign push       = inflight_q & ~redirect_valid;
  assign count_base = count_q - {1'b0, pop};
  // Only issue when the slot is guaranteed once the in-flight word lands.
  assign issue      = rst_n & ~redirect_valid &
                      ((count_base + {1'b0, inflight_q}) < QFULL);

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    last_inst_d   = last_inst_q;
    last_pc_d     = last_pc_q;

    if (inst_valid) begin
      last_inst_d = qinst_q[rd_ptr_q];
      last_pc_d   = qpc_q[rd_ptr_q];
    end

    if (redirect_valid) begin
      // Flush queue and in-flight word; a concurrent pop is dropped.
      pc_d     = redirect_pc;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 32'd1;
      end
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q - {1'b0, pop} + {1'b0, push};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
      last_inst_q   <= 32'd0;
      last_pc_q     <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      last_inst_q   <= last_inst_d;
      last_pc_q     <= last_pc_d;
    end
  end

  // Queue storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      qinst_q[wr_ptr_q] <= cache_data;
      qpc_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: cache model, PC-order scoreboard, and a
// second instance exercising PC wrap-around.
module tb_inst_fetch;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n, inst_ready, redirect_valid;
  logic [31:0] redirect_pc, cache_addr, cache_data, inst, inst_pc;
  logic        inst_valid;

  logic        rst2_n;
  logic [31:0] cache_addr2, cache_data2, inst2, inst_pc2;
  logic        inst_valid2;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  logic [31:0] sb_q [$];
  logic [31:0] old_head;

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cache_addr(cache_addr), .cache_data(cache_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_ready(inst_ready), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc)
  );

  inst_fetch #(.RESET_PC(32'hFFFF_FFFE), .QDEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst2_n),
    .cache_addr(cache_addr2), .cache_data(cache_data2),
    .redirect_valid(1'b0), .redirect_pc(32'd0),
    .inst_ready(1'b1), .inst_valid(inst_valid2),
    .inst(inst2), .inst_pc(inst_pc2)
  );

  // Cache model: word returned one clock after the address is sampled.
  always @(posedge clk) begin
    cache_data  <= cache_addr ^ K;
    cache_data2 <= cache_addr2 ^ K;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Drive inputs for the next posedge, score any handshake, wait to next negedge.
  task automatic step(input logic rs, input logic rd, input logic rv, input logic [31:0] rp);
    logic [31:0] e;
    rst_n = rs; inst_ready = rd; redirect_valid = rv; redirect_pc = rp;
    if (rs && !rv && u_dut.inflight_q && u_dut.count_q == 2'd2)
      chk("push_into_full", {31'd0, inst_valid && rd}, 32'd1);
    if (rs && !rv && rd && inst_valid) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        fail_cnt++;
        $error("FAIL sb_underflow observed_pc=%08h expected=none", inst_pc);
      end else begin
        e = sb_q.pop_front();
        chk("inst_pc", inst_pc, e);
        chk("inst", inst, e ^ K);
      end
    end
    @(negedge clk);
  endtask

  task automatic sb_restart(input logic [31:0] base, input int n);
    sb_q.delete();
    for (int i = 0; i < n; i++) sb_q.push_back(base + 32'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    rst2_n = 1'b0;
    @(negedge clk);
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);

    // Reset state
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_cache_addr", cache_addr, 32'd0);

    // Free run: first word valid two edges after reset release
    sb_restart(32'd0, 40);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("lat_edge1_valid", {31'd0, inst_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("lat_edge2_valid", {31'd0, inst_valid}, 32'd1);
    chk("lat_edge2_pc", inst_pc, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("stream_pc1", inst_pc, 32'd1);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("stream_pc2", inst_pc, 32'd2);

    // Backpressure: head 2 held, word 3 fills the queue, fetch freezes at 4
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0);
      chk("stall_valid", {31'd0, inst_valid}, 32'd1);
      chk("stall_head", inst_pc, 32'd2);
      if (i >= 1) chk("stall_addr", cache_addr, 32'd4);
    end
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'd0);

    // Redirect while queue full
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("full_valid", {31'd0, inst_valid}, 32'd1);
    old_head = sb_q[0];
    step(1'b1, 1'b0, 1'b1, 32'h0000_0100);
    sb_restart(32'h0000_0100, 32);
    chk("redir_flush_valid", {31'd0, inst_valid}, 32'd0);
    chk("redir_hold_head", inst_pc, old_head);
    chk("redir_addr", cache_addr, 32'h0000_0100);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("redir_e1_valid", {31'd0, inst_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("redir_e2_valid", {31'd0, inst_valid}, 32'd1);
    chk("redir_e2_pc", inst_pc, 32'h0000_0100);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'd0);

    // Redirect coinciding with a pop: head is not consumed
    chk("rpop_valid", {31'd0, inst_valid}, 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0040);
    sb_restart(32'h0000_0040, 32);
    chk("rpop_flush_valid", {31'd0, inst_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("rpop_e2_valid", {31'd0, inst_valid}, 32'd1);
    chk("rpop_e2_pc", inst_pc, 32'h0000_0040);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'd0);

    // Reset mid-operation with a full queue
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'd0);
    chk("pre_rst_valid", {31'd0, inst_valid}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 32'd0);
    chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mid_rst_inst", inst, 32'd0);
    chk("mid_rst_inst_pc", inst_pc, 32'd0);
    chk("mid_rst_addr", cache_addr, 32'd0);
    sb_restart(32'd0, 64);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("mid_rst_e1_valid", {31'd0, inst_valid}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("mid_rst_e2_valid", {31'd0, inst_valid}, 32'd1);
    chk("mid_rst_e2_pc", inst_pc, 32'd0);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'd0);

    // PC wrap on the second instance
    rst2_n = 1'b1;
    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk("wrap_e1_valid", {31'd0, inst_valid2}, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_valid", {31'd0, inst_valid2}, 32'd1);
      chk("wrap_pc", inst_pc2, 32'hFFFF_FFFE + 32'(i));
      chk("wrap_inst", inst2, (32'hFFFF_FFFE + 32'(i)) ^ K);
      step(1'b1, 1'b1, 1'b0, 32'd0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
